fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction fetch stage of the SAP-2 CPU, sitting directly upstream of the execute/control logic. Owns the 16-bit program counter, reads 1–3 byte instructions from memory one byte per 4-cycle slot, presents opcode plus operand bytes to execute through a valid/ready handshake, then waits for execute to finish. On completion it applies a taken jump by loading the PC from the fetched operands, or stops fetching on halt.

## Interface
- `ADDR_WIDTH`, 16: program counter / memory address width.
- `DATA_WIDTH`, 8: memory data and instruction byte width.
- `RESET_VECTOR`, 16'hF000: PC value after reset (ROM base).

- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `mem_addr`  output  ADDR_WIDTH  read address, equals `pc` while reading.
- `mem_rd`  output  1  read strobe, high for one cycle per byte.
- `mem_data`  input  DATA_WIDTH  read data, valid exactly one cycle after `mem_rd`.
- `pc`  output  ADDR_WIDTH  current program counter.
- `opcode`  output  DATA_WIDTH  fetched byte 0.
- `operand_lo`  output  DATA_WIDTH  fetched byte 1 (temp_1).
- `operand_hi`  output  DATA_WIDTH  fetched byte 2 (temp_2).
- `ir_valid`  output  1  instruction ready for execute.
- `ir_ready`  input  1  execute accepts instruction.
- `exec_done`  input  1  execute finished current instruction (1-cycle pulse).
- `branch_taken`  input  1  qualifies `exec_done`: load PC from operands.
- `halt_req`  input  1  qualifies `exec_done`: stop fetching.
- `halted`  output  1  sequencer in HALT state.

## Operation
- States: ADDR, WAIT, LATCH, NEXT, ISSUE, EXEC, HALT.
- ADDR: `mem_addr`=`pc`, `mem_rd`=1 → WAIT.
- WAIT: memory latency cycle → LATCH.
- LATCH: capture `mem_data` into opcode/operand_lo/operand_hi by byte index 0/1/2 → NEXT. On byte 0, operand_lo/hi clear to 00.
- NEXT: `pc`←`pc`+1 (wraps FFFF→0000). If byte index+1 < `instr_length(opcode)` → ADDR, index+1; else → ISSUE, index←0.
- ISSUE: `ir_valid`=1, holding opcode/operands stable, until `ir_ready`=1 in the same cycle → EXEC.
- EXEC: wait for `exec_done`. On it: if `branch_taken`, `pc`←{operand_hi, operand_lo}; if `halt_req` → HALT, else → ADDR.
- HALT: no reads, `halted`=1; only reset exits.
- `branch_taken` and `halt_req` in the same `exec_done` cycle: PC load happens, then HALT.
- `ir_ready` outside ISSUE and `exec_done`/`branch_taken`/`halt_req` outside EXEC are ignored.
- Unknown opcodes have length 1.
- Reset, including mid-fetch or mid-EXEC: state ADDR, index 0, `pc`=RESET_VECTOR, opcode/operands 00, `ir_valid`=0, `mem_rd`=0, `halted`=0. No partial instruction survives.

## Timing
- Cycle 0 = first cycle with `reset` high. One byte costs 4 cycles (ADDR, WAIT, LATCH, NEXT).
- `opcode` is valid from cycle 3. The `pc` increment is visible from cycle 4.
- For 1/2/3-byte instructions, `ir_valid` first asserts at cycle 4/8/12 after fetch start.
- The earliest `exec_done` is the cycle after the handshake. The next ADDR follows `exec_done` by one cycle.
- A taken jump's new `pc` is visible in the ADDR cycle, which is also the first read from the target.
- All outputs are registered except `mem_addr` (which equals `pc`), `mem_rd`, and `ir_valid`. These three are decoded from state.

## Structure
- `arch_defs_pkg`: opcode enum (existing) plus a new function `instr_length(opcode)` returning 1–3. This is the single source for instruction length, shared with the control unit.
- `fetch_state_t` enum: local to the module.
- No sub-modules. The PC is a plain register inside the block. A separate counter module is not warranted.

## Test plan
- Reset release with ROM[F000]=LDI_A, 80 → `opcode`=LDI_A at cycle 3, `operand_lo`=80 at cycle 7, `ir_valid` at cycle 8, `pc`=F002.
- JN, 07, F0 at F002; `exec_done` with `branch_taken`=1 → `ir_valid` 12 cycles after fetch start, `pc`=F005, then `pc`=F007 and next read at F007.
- Same JN, `branch_taken`=0 → next read at F005.
- Hold `ir_ready`=0 for 5 cycles in ISSUE → `ir_valid` and outputs stable, no `mem_rd`, `pc` unchanged.
- HLT executed with `halt_req`=1 → `halted`=1 and `mem_rd` stays 0 for 20 cycles. Then reset → `pc`=F000, fetch resumes.
- Reset pulse during byte 2 of a 3-byte fetch → `pc`=F000, operands 00, `ir_valid` never asserts for the aborted instruction. 1-byte instruction at FFFF → `pc` wraps to 0000.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// ============================================================================
// Module   : arch_defs_pkg
// Brief    : SAP-2 opcode encodings and the shared instruction-length decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arch_defs_pkg;

  typedef enum logic [7:0] {
    OP_NOP     = 8'h00,
    OP_INR_B   = 8'h04,
    OP_DCR_B   = 8'h05,
    OP_LDI_B   = 8'h06,
    OP_INR_C   = 8'h0C,
    OP_DCR_C   = 8'h0D,
    OP_LDI_C   = 8'h0E,
    OP_RAL     = 8'h17,
    OP_RAR     = 8'h1F,
    OP_CMA     = 8'h2F,
    OP_STA     = 8'h32,
    OP_LDA     = 8'h3A,
    OP_INR_A   = 8'h3C,
    OP_DCR_A   = 8'h3D,
    OP_LDI_A   = 8'h3E,
    OP_HLT     = 8'h76,
    OP_MOV_A_B = 8'h78,
    OP_MOV_A_C = 8'h79,
    OP_ADD_B   = 8'h80,
    OP_ADD_C   = 8'h81,
    OP_SUB_B   = 8'h90,
    OP_SUB_C   = 8'h91,
    OP_ANA_B   = 8'hA0,
    OP_XRA_B   = 8'hA8,
    OP_ORA_B   = 8'hB0,
    OP_JNZ     = 8'hC2,
    OP_JMP     = 8'hC3,
    OP_RET     = 8'hC9,
    OP_JZ      = 8'hCA,
    OP_CALL    = 8'hCD,
    OP_OUT     = 8'hD3,
    OP_IN      = 8'hDB,
    OP_ANI     = 8'hE6,
    OP_XRI     = 8'hEE,
    OP_ORI     = 8'hF6,
    OP_JN      = 8'hFA
  } opcode_t;

  // Anything not listed (including undefined encodings) is a single byte.
  function automatic logic [1:0] instr_length(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    case (op)
      OP_LDI_A, OP_LDI_B, OP_LDI_C,
      OP_ANI, OP_ORI, OP_XRI,
      OP_IN, OP_OUT:                  len = 2'd2;
      OP_LDA, OP_STA, OP_JMP, OP_JZ,
      OP_JNZ, OP_JN, OP_CALL:         len = 2'd3;
      default:                        len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module   : fetch_sequencer_if
// Brief    : Memory read port and fetch/execute handshake of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0] operand_lo;
  logic [DATA_WIDTH-1:0] operand_hi;
  logic                  ir_valid;
  logic                  ir_ready;
  logic                  exec_done;
  logic                  branch_taken;
  logic                  halt_req;
  logic                  halted;

  modport master (
    output mem_addr, mem_rd, pc, opcode, operand_lo, operand_hi, ir_valid, halted,
    input  mem_data, ir_ready, exec_done, branch_taken, halt_req
  );

  modport slave (
    input  mem_addr, mem_rd, pc, opcode, operand_lo, operand_hi, ir_valid, halted,
    output mem_data, ir_ready, exec_done, branch_taken, halt_req
  );

endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : SAP-2 instruction fetch: PC, byte-serial fetch, issue, branch/halt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
  import arch_defs_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hF000
) (
  input  wire logic       clk,
  input  wire logic       reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_ADDR  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_LATCH = 3'd2,
    ST_NEXT  = 3'd3,
    ST_ISSUE = 3'd4,
    ST_EXEC  = 3'd5,
    ST_HALT  = 3'd6
  } fetch_state_t;

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [1:0]            r_idx;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_opcode;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [DATA_WIDTH-1:0] r_hi;
  logic                  r_halted;
  logic [1:0]            w_len;
  logic                  w_more;

  assign w_len  = instr_length(r_opcode);
  assign w_more = (r_idx + 2'd1) < w_len;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ADDR:  w_state_next = ST_WAIT;
      ST_WAIT:  w_state_next = ST_LATCH;
      ST_LATCH: w_state_next = ST_NEXT;
      ST_NEXT:  w_state_next = w_more ? ST_ADDR : ST_ISSUE;
      ST_ISSUE: if (bus.ir_ready) w_state_next = ST_EXEC;
      ST_EXEC:  if (bus.exec_done) w_state_next = bus.halt_req ? ST_HALT : ST_ADDR;
      ST_HALT:  w_state_next = ST_HALT;
      default:  w_state_next = ST_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_ADDR;
      r_idx    <= 2'd0;
      r_pc     <= RESET_VECTOR;
      r_rdata  <= '0;
      r_opcode <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_halted <= (w_state_next == ST_HALT);
      case (r_state)
        // Memory data is only guaranteed during the WAIT cycle, so hold it here.
        ST_WAIT: r_rdata <= bus.mem_data;
        ST_LATCH: begin
          case (r_idx)
            2'd0: begin
              r_opcode <= r_rdata;
              r_lo     <= '0;
              r_hi     <= '0;
            end
            2'd1:    r_lo <= r_rdata;
            default: r_hi <= r_rdata;
          endcase
        end
        ST_NEXT: begin
          r_pc  <= r_pc + ADDR_WIDTH'(1);
          r_idx <= w_more ? (r_idx + 2'd1) : 2'd0;
        end
        ST_EXEC: begin
          if (bus.exec_done && bus.branch_taken)
            r_pc <= ADDR_WIDTH'({r_hi, r_lo});
        end
        default: ;
      endcase
    end
  end

  // Read strobe is suppressed while reset is held, even though the state sits in ADDR.
  assign bus.mem_rd     = (r_state == ST_ADDR) && reset;
  assign bus.mem_addr   = r_pc;
  assign bus.ir_valid   = (r_state == ST_ISSUE);
  assign bus.pc         = r_pc;
  assign bus.opcode     = r_opcode;
  assign bus.operand_lo = r_lo;
  assign bus.operand_hi = r_hi;
  assign bus.halted     = r_halted;

endmodule

`default_nettype wire
